// File: rtl/uart_stop_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_stop_check                                            |
// | Description : UART stop-bit checker with majority vote and framing error |
// |               flag. Optional break detect: UART_STOP_BREAK_DETECT_EN.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_stop_check #(
  parameter int OSR         = 16,
  parameter int STOP_HALVES = 2,
  parameter int VOTE        = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_rx,
  input  logic i_start,
  input  logic i_data_zero,
  output logic o_busy,
  output logic o_ready,
  output logic o_frame_err,
  output logic o_break
);

  localparam int c_CW  = $clog2(2 * OSR + 2);
  localparam int c_V   = (VOTE == 3) ? 1 : 0;
  localparam int c_S0  = OSR / 2;
  localparam int c_S1  = (STOP_HALVES == 3) ? (OSR + OSR / 4) : (OSR + OSR / 2);
  localparam bit c_TWO = (STOP_HALVES > 2);
  localparam int c_END = (c_TWO ? c_S1 : c_S0) + c_V;

  localparam logic [c_CW-1:0] c_LO0  = c_CW'(c_S0 - c_V);
  localparam logic [c_CW-1:0] c_HI0  = c_CW'(c_S0 + c_V);
  localparam logic [c_CW-1:0] c_LO1  = c_CW'(c_S1 - c_V);
  localparam logic [c_CW-1:0] c_HI1  = c_CW'(c_S1 + c_V);
  localparam logic [c_CW-1:0] c_ENDL = c_CW'(c_END);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STOP = 2'd1
`ifdef UART_STOP_BREAK_DETECT_EN
    , S_BRK = 2'd2
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]      r_ones, w_ones_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, r_ready, r_ferr, r_brk;
  logic            w_ready_nxt, w_ferr_nxt, w_brk_nxt;
  logic            w_win, w_dec, w_bit;
  logic [1:0]      w_votes;

`ifdef UART_STOP_BREAK_DETECT_EN
  logic r_zero, w_zero_nxt;
`else
  logic w_unused_zero;
  assign w_unused_zero = i_data_zero;
`endif

  // Vote window spans sample-1..sample+1 (or just the sample when VOTE=1);
  // the decision is taken on the last tick of the window.
  assign w_win   = ((r_cnt >= c_LO0) && (r_cnt <= c_HI0)) ||
                   (c_TWO && (r_cnt >= c_LO1) && (r_cnt <= c_HI1));
  assign w_dec   = (r_cnt == c_HI0) || (c_TWO && (r_cnt == c_HI1));
  assign w_votes = r_ones + {1'b0, i_rx};
  assign w_bit   = (VOTE == 3) ? w_votes[1] : i_rx;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ones_nxt  = r_ones;
    w_err_nxt   = r_err;
    w_ready_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_brk_nxt   = 1'b0;
`ifdef UART_STOP_BREAK_DETECT_EN
    w_zero_nxt  = r_zero;
`endif
    case (r_state)
      S_IDLE: begin
        // A start coinciding with the completion pulse belongs to no frame.
        if (i_start && !r_ready) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
          w_ones_nxt  = '0;
          w_err_nxt   = 1'b0;
`ifdef UART_STOP_BREAK_DETECT_EN
          w_zero_nxt  = i_data_zero;
`endif
        end
      end
      S_STOP: begin
        if (i_en) begin
          w_cnt_nxt = r_cnt + c_CW'(1);
          if (w_win) w_ones_nxt = w_votes;
          if (w_dec) begin
            w_ones_nxt = '0;
            if (!w_bit) w_err_nxt = 1'b1;
          end
          if (r_cnt == c_ENDL) begin
            w_ready_nxt = 1'b1;
            w_ferr_nxt  = w_err_nxt;
            w_state_nxt = S_IDLE;
`ifdef UART_STOP_BREAK_DETECT_EN
            if (r_zero && w_err_nxt) begin
              w_brk_nxt   = 1'b1;
              w_state_nxt = S_BRK;
            end
`endif
          end
        end
      end
`ifdef UART_STOP_BREAK_DETECT_EN
      S_BRK: begin
        if (i_en && i_rx) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ones  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
`ifdef UART_STOP_BREAK_DETECT_EN
      r_zero  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ones  <= w_ones_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ready <= w_ready_nxt;
      r_ferr  <= w_ferr_nxt;
      r_brk   <= w_brk_nxt;
`ifdef UART_STOP_BREAK_DETECT_EN
      r_zero  <= w_zero_nxt;
`endif
    end
  end

  assign o_busy      = r_busy;
  assign o_ready     = r_ready;
  assign o_frame_err = r_ferr;
  assign o_break     = r_brk;

endmodule
`default_nettype wire

// File: tb/tb_uart_stop_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_stop_check                                         |
// | Description : Self-checking bench for uart_stop_check (default and       |
// |               two-stop-bit instances).                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_stop_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rx, start, dz;
  logic busy, ready, ferr, brk;
  logic busy4, ready4, ferr4, brk4;

  int n_tests = 0;
  int n_fail  = 0;

  uart_stop_check dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx), .i_start(start),
    .i_data_zero(dz), .o_busy(busy), .o_ready(ready),
    .o_frame_err(ferr), .o_break(brk)
  );

  uart_stop_check #(.OSR(16), .STOP_HALVES(4), .VOTE(3)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx), .i_start(start),
    .i_data_zero(dz), .o_busy(busy4), .o_ready(ready4),
    .o_frame_err(ferr4), .o_break(brk4)
  );

  typedef struct {
    logic [31:0] pat;      // bit j = rx level on stop tick j
    bit          mid;      // extra start pulse while busy
    bit          zero;     // i_data_zero with the start pulse
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; en = 1'b1; rx = 1'b1; dz = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // Cycle 0 carries the start pulse; outputs of cycle n are seen at its negedge.
  task automatic run_frame(input logic [31:0] pat, input int period, input bit sel4,
                           input bit mid, input bit restart, input bit zero,
                           output int got_n, output logic got_ferr,
                           output logic got_brk, output bit busy_ok);
    got_n = -1; got_ferr = 1'b0; got_brk = 1'b0; busy_ok = 1'b1;
    @(negedge clk); start = 1'b1; dz = zero; en = 1'b1; rx = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if ((sel4 ? ready4 : ready) === 1'b1) begin
        got_n    = n;
        got_ferr = sel4 ? ferr4 : ferr;
        got_brk  = sel4 ? brk4 : brk;
        start    = restart;
        break;
      end
      if ((sel4 ? busy4 : busy) !== 1'b1) busy_ok = 1'b0;
      if (mid && n == 5) start = 1'b1;
      en = ((n - 1) % period == 0);
      rx = (((n - 1) / period) < 32) ? pat[(n - 1) / period] : 1'b1;
    end
    en = 1'b1; rx = 1'b1; dz = 1'b0;
  endtask

  initial begin
    int   got_n, rdy_n, brk_n, rdy_cnt, first_low;
    logic got_ferr, got_brk, rdy_ferr;
    bit   busy_ok, relapse, saw;
    logic exp_brk;

    vecs[0] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FC7F, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FF7F, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FCFF, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FD7F, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_0380, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FDFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FBBF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; en = 1'b0; rx = 1'b1; dz = 1'b0;
    repeat (2) @(negedge clk);
    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(negedge clk);
    check("rst_busy",  busy,  0);
    check("rst_ready", ready, 0);
    check("rst_ferr",  ferr,  0);
    check("rst_break", brk,   0);
    start = 1'b0; rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_frame(vecs[i].pat, 1, 1'b0, vecs[i].mid, 1'b0, vecs[i].zero,
                got_n, got_ferr, got_brk, busy_ok);
`ifdef UART_STOP_BREAK_DETECT_EN
      exp_brk = vecs[i].zero & vecs[i].exp_ferr;
`else
      exp_brk = 1'b0;
`endif
      check($sformatf("vec%0d_latency", i), got_n, 11);
      check($sformatf("vec%0d_ferr", i), got_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_break", i), got_brk, exp_brk);
      check($sformatf("vec%0d_busy", i), busy_ok, 1);
    end

    // Start in the same cycle as the ready pulse is dropped.
    do_reset();
    run_frame(32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b1, 1'b0, got_n, got_ferr, got_brk, busy_ok);
    check("restart_latency", got_n, 11);
    @(negedge clk); start = 1'b0;
    check("restart_ignored_busy",  busy,  0);
    check("restart_ignored_ready", ready, 0);

    // Two stop bits, tick every 4th cycle, second stop bit low.
    do_reset();
    run_frame(32'h0000_FFFF, 4, 1'b1, 1'b0, 1'b0, 1'b0, got_n, got_ferr, got_brk, busy_ok);
    check("two_stop_latency", got_n, 102);
    check("two_stop_ferr", got_ferr, 1);
    check("two_stop_busy", busy_ok, 1);

    // Reset three ticks into the stop bit.
    do_reset();
    @(negedge clk); start = 1'b1; en = 1'b1; rx = 1'b1;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy_after", busy, 0);
    saw = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (ready === 1'b1) saw = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_ready", saw, 0);
    run_frame(32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0, 1'b0, got_n, got_ferr, got_brk, busy_ok);
    check("midrst_fresh_latency", got_n, 11);
    check("midrst_fresh_ferr", got_ferr, 0);

    // Line held low for 40 ticks with all-zero data.
    do_reset();
    @(negedge clk); start = 1'b1; dz = 1'b1; en = 1'b1; rx = 1'b0;
    rdy_n = -1; brk_n = -1; rdy_cnt = 0; first_low = -1; relapse = 1'b0; rdy_ferr = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start = 1'b0; dz = 1'b0;
      if (ready === 1'b1) begin rdy_n = n; rdy_cnt++; rdy_ferr = ferr; end
      if (brk === 1'b1) brk_n = n;
      if (busy === 1'b0 && first_low < 0) first_low = n;
      if (first_low >= 0 && busy === 1'b1) relapse = 1'b1;
`ifdef UART_STOP_BREAK_DETECT_EN
      if (n == 20) start = 1'b1;
`endif
      rx = ((n - 1) < 40) ? 1'b0 : 1'b1;
    end
    check("brk_ready_cycle", rdy_n, 11);
    check("brk_ready_count", rdy_cnt, 1);
    check("brk_ferr", rdy_ferr, 1);
`ifdef UART_STOP_BREAK_DETECT_EN
    check("brk_pulse_cycle", brk_n, 11);
    check("brk_busy_fall", first_low, 42);
`else
    check("brk_pulse_cycle", brk_n, -1);
    check("brk_busy_fall", first_low, 11);
`endif
    check("brk_busy_relapse", relapse, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
